// File: rtl/seq_barrel_shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the sequential barrel shifter:
//   op_t      - shift operation encodings (SLL, SRL, SRA, ROL)
//   state_t   - control FSM states (IDLE, BUSY, DONE)
//   calc_lat  - number of BUSY cycles needed to resolve every binary stage
// Optional feature macro: SHIFTER_ROTATE_EN (consumed by shift_stage).
// ---------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling division: a partial last group still costs a whole cycle.
  function automatic int calc_lat(input int shamt_w, input int stages_per_cycle);
    return (shamt_w + stages_per_cycle - 1) / stages_per_cycle;
  endfunction

endpackage

// File: rtl/seq_barrel_shifter_if.sv
// ---------------------------------------------------------------------------
// seq_barrel_shifter_if
// Request/response bundle for the sequential barrel shifter.
//   in_valid/in_ready   - request handshake
//   in_data             - operand (WIDTH bits)
//   in_shamt            - unsigned shift amount (SHAMT_W bits)
//   in_op               - 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid/out_ready - result handshake
//   out_data            - registered result (WIDTH bits)
// Modports: master (requester / consumer side), slave (the shifter).
// ---------------------------------------------------------------------------
interface seq_barrel_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/seq_barrel_shifter_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
// One combinational binary stage of the barrel shifter: shifts by the fixed
// distance DIST when enable is high, otherwise passes data through.
//   data    in  WIDTH  stage input
//   enable  in  1      this stage's shift-amount bit
//   op      in  op_t   operation
//   shifted out WIDTH  stage output
// Optional feature macro: SHIFTER_ROTATE_EN. When undefined, op ROL passes
// data through unmodified.
// ---------------------------------------------------------------------------
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  op_t              op,
  output logic [WIDTH-1:0] shifted
);

  // For SRA the MSB of every intermediate value is still the original
  // operand's sign bit, so filling from data[WIDTH-1] is correct at each stage.
  always_comb begin
    shifted = data;
    if (enable) begin
      case (op)
        OP_SLL:  shifted = data << DIST;
        OP_SRL:  shifted = data >> DIST;
        OP_SRA:  shifted = $signed(data) >>> DIST;
        OP_ROL:
`ifdef SHIFTER_ROTATE_EN
          shifted = (data << DIST) | (data >> (WIDTH - DIST));
`else
          shifted = data;
`endif
        default: shifted = data;
      endcase
    end
  end

endmodule

// File: rtl/seq_barrel_shifter.sv
// ---------------------------------------------------------------------------
// seq_barrel_shifter
// Multi-cycle barrel shifter for the ALU shift path. Operands are latched on
// acceptance; STAGES_PER_CYCLE binary stages are resolved per clock, largest
// distance first, and the result is held in a register until consumed.
//   clock    in   sole clock, rising edge
//   reset_n  in   synchronous, active-low reset
//   bus      slave modport of seq_barrel_shifter_if (valid/ready both sides)
// Parameters: WIDTH (power of two >= 2), SHAMT_W, STAGES_PER_CYCLE.
// Optional feature macro: SHIFTER_ROTATE_EN (enables op 11 = rotate left).
// ---------------------------------------------------------------------------
module seq_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int SHAMT_W          = $clog2(WIDTH),
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  seq_barrel_shifter_if.slave  bus
);

  localparam int LAT   = calc_lat(SHAMT_W, STAGES_PER_CYCLE);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [WIDTH-1:0]   stage_out;
  logic [SHAMT_W-1:0] shamt_q;
  op_t                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               last_stage;
  logic [WIDTH-1:0]   grp_out [LAT];

  assign accept     = bus.in_valid & bus.in_ready;
  assign last_stage = (state_q == BUSY) && (cnt_q == CNT_W'(LAT - 1));
  assign bus.out_data = out_data_q;

  // Group g handles stages SHAMT_W-1-g*SPC down to SHAMT_W-g*SPC-SPC; positions
  // that fall below stage 0 (partial last group) are plain wires.
  for (genvar g = 0; g < LAT; g++) begin : g_grp
    logic [WIDTH-1:0] chain [STAGES_PER_CYCLE+1];
    assign chain[0] = work_q;
    for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_pos
      localparam int K = SHAMT_W - 1 - g * STAGES_PER_CYCLE - j;
      if (K >= 0) begin : g_stage
        shift_stage #(
          .WIDTH (WIDTH),
          .DIST  (1 << K)
        ) u_stage (
          .data    (chain[j]),
          .enable  (shamt_q[K]),
          .op      (op_q),
          .shifted (chain[j+1])
        );
      end else begin : g_pass
        assign chain[j+1] = chain[j];
      end
    end
    assign grp_out[g] = chain[STAGES_PER_CYCLE];
  end

  // The stage counter selects which group acts on the working register.
  always_comb begin
    stage_out = work_q;
    for (int g = 0; g < LAT; g++) begin
      if (cnt_q == CNT_W'(g)) begin
        stage_out = grp_out[g];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = BUSY;
      BUSY:    if (last_stage) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In DONE, in_ready follows out_ready so a consumed result and a new
  // request can share the same edge.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: bus.in_ready = 1'b1;
      DONE: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = 1'b1;
      end
      default: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
      end
    endcase
  end

  // Accept can only happen in IDLE or DONE, so it never collides with the
  // BUSY update. out_data changes only on DONE entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      work_q     <= '0;
      out_data_q <= '0;
      shamt_q    <= '0;
      op_q       <= OP_SLL;
      cnt_q      <= '0;
    end else if (accept) begin
      work_q  <= bus.in_data;
      shamt_q <= bus.in_shamt;
      op_q    <= op_t'(bus.in_op);
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      work_q <= stage_out;
      if (last_stage) begin
        out_data_q <= stage_out;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_barrel_shifter
// Self-checking bench for seq_barrel_shifter (WIDTH=32, one stage per cycle).
// Directed cases followed by random requests checked against a one-line
// arithmetic shift model. Optional feature macro: SHIFTER_ROTATE_EN.
// ---------------------------------------------------------------------------
module tb_seq_barrel_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int LAT     = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  seq_barrel_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  seq_barrel_shifter #(
    .WIDTH            (WIDTH),
    .SHAMT_W          (SHAMT_W),
    .STAGES_PER_CYCLE (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the whole shift in one arithmetic step.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] o);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
      default: begin
`ifdef SHIFTER_ROTATE_EN
        if (s == 5'd0) return d;
        return (d << s) | (d >> (6'd32 - {1'b0, s}));
`else
        return d;
`endif
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one request from IDLE, scribble on the inputs while busy, and
  // return the number of edges from acceptance until out_valid.
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] s,
                               input logic [1:0] o, output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_op    = o;
    tick();
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = $urandom;
      bus.in_shamt = 5'($urandom);
      bus.in_op    = 2'($urandom);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp, input int lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({tag, "_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] d;
    logic [31:0] exp;
    logic [4:0]  s;
    logic [1:0]  o;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_data", bus.out_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // Directed shifts
    applyStimulus(32'h0000_00FF, 5'd8, 2'b00, lat);
    checkOutput("sll8", 32'h0000_FF00, lat);
    applyStimulus(32'h8000_0000, 5'd31, 2'b10, lat);
    checkOutput("sra31", 32'hFFFF_FFFF, lat);
    applyStimulus(32'h8000_0000, 5'd31, 2'b01, lat);
    checkOutput("srl31", 32'h0000_0001, lat);

    // Zero shift amount keeps the full latency and returns the operand
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'hDEAD_BEEF, 5'd0, 2'(i), lat);
      checkOutput($sformatf("zero_op%0d", i), 32'hDEAD_BEEF, lat);
    end

    // Backpressure: result held, new request not taken until out_ready
    applyStimulus(32'h1234_5678, 5'd4, 2'b01, lat);
    check("bp_lat", lat, LAT);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0001;
    bus.in_shamt = 5'd31;
    bus.in_op    = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_data", bus.out_data, 32'h0123_4567);
      check("bp_hold_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    check("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp_b2b_busy_valid", {31'b0, bus.out_valid}, 32'd0);
    check("bp_b2b_busy_ready", {31'b0, bus.in_ready}, 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("bp_b2b", 32'h8000_0000, lat);

    // Reset in the middle of BUSY discards the operation
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAA_5555;
    bus.in_shamt = 5'd3;
    bus.in_op    = 2'b00;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("midrst_out_data", bus.out_data, 32'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    check("midrst_no_stale", seen, 0);

    // Op 11: rotate when enabled, pass-through otherwise
`ifdef SHIFTER_ROTATE_EN
    exp = 32'h0000_0003;
`else
    exp = 32'h8000_0001;
`endif
    applyStimulus(32'h8000_0001, 5'd1, 2'b11, lat);
    checkOutput("op11", exp, lat);

    // Random requests against the reference model
    for (int i = 0; i < 40; i++) begin
      d   = $urandom;
      s   = 5'($urandom);
      o   = 2'($urandom);
      exp = model(d, s, o);
      applyStimulus(d, s, o, lat);
      checkOutput($sformatf("rand%0d_op%0d_s%0d", i, o, s), exp, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
